// File: rtl/led_pattern_seq_pkg.sv
// ----------------------------------------------------------------------------
// led_pattern_seq_pkg
//   Shared encodings for the LED pattern sequencer:
//     mode_e  : DIP-switch mode encodings (MODE_PASS..MODE_COUNT)
//     state_e : sequencer FSM states (ST_RUN, ST_HOLD)
//     max_int : elaboration-time helper used for width sizing
// ----------------------------------------------------------------------------
package led_pattern_seq_pkg;

   typedef enum logic [1:0] {
      MODE_PASS  = 2'b00,
      MODE_SWEEP = 2'b01,
      MODE_BLINK = 2'b10,
      MODE_COUNT = 2'b11
   } mode_e;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// ----------------------------------------------------------------------------
// led_tick_gen
//   Step divider. Counts 0..div_max and raises tick on the terminal count,
//   wrapping to 0 on that same edge.
//   Ports:
//     clk      in   system clock
//     rst_n    in   asynchronous active-low reset
//     clr      in   synchronous clear of the count (wins over en)
//     en       in   count enable; count is frozen when low
//     div_max  in   terminal count (DIV-1)
//     tick     out  1 on the cycle the count equals div_max while enabled
// ----------------------------------------------------------------------------
module led_tick_gen #(
   parameter int CNT_W = 27
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] div_max,
   output logic             tick
);

   logic [CNT_W-1:0] div_q, div_d;

   assign tick = en && !clr && (div_q == div_max);

   always_comb begin
      div_d = div_q;
      if (clr || tick) begin
         div_d = '0;
      end else if (en) begin
         div_d = div_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

endmodule

// File: rtl/led_pattern_seq.sv
// ----------------------------------------------------------------------------
// led_pattern_seq
//   LED pattern sequencer: PASS / SWEEP / BLINK / COUNT selected by mode,
//   free-running or one-shot with a done pulse.
//   Ports:
//     clk      in   system clock
//     rst_n    in   asynchronous active-low reset
//     mode     in   2  00 PASS, 01 SWEEP, 10 BLINK, 11 COUNT
//     oneshot  in   1  run one sequence then hold
//     trig     in   1  restarts a held one-shot sequence
//     pass_in  in   N_LED pattern shown in PASS mode
//     duty     in   4  PWM duty (only with LED_SEQ_PWM_EN)
//     led      out  N_LED registered LED drive
//     busy     out  1  sequence running
//     done     out  1  one-cycle pulse at the end of a one-shot sequence
//   Build option: define LED_SEQ_PWM_EN to add the duty input and gate the
//   LED drive with a 4-bit free-running PWM.
// ----------------------------------------------------------------------------
module led_pattern_seq
   import led_pattern_seq_pkg::*;
#(
   parameter int N_LED     = 4,
   parameter int STEP_DIV  = 5_000_000,
   parameter int BLINK_DIV = 8_000_000,
   parameter int BLINK_CNT = 3,
   parameter int CNT_W     = 27
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       mode,
   input  logic             oneshot,
   input  logic             trig,
   input  logic [N_LED-1:0] pass_in,
`ifdef LED_SEQ_PWM_EN
   input  logic [3:0]       duty,
`endif
   output logic [N_LED-1:0] led,
   output logic             busy,
   output logic             done
);

   // Step counter must reach the last index of the longest sequence.
   localparam int STEP_W = max_int(N_LED,
                           max_int($clog2(2*N_LED), $clog2(2*BLINK_CNT)));

   localparam logic [STEP_W-1:0] SWEEP_LAST = STEP_W'(2*N_LED - 1);
   localparam logic [STEP_W-1:0] BLINK_LAST = STEP_W'(2*BLINK_CNT - 1);
   localparam logic [STEP_W-1:0] COUNT_LAST = STEP_W'((1 << N_LED) - 1);
   localparam logic [N_LED-1:0]  ONE        = N_LED'(1);

   mode_e             mode_q, mode_d;
   state_e            state_q, state_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [N_LED-1:0]  led_q, led_d;
   logic              done_q, done_d;

   logic              mode_chg, is_pass, tick, seq_last, div_clr, div_en;
   logic [CNT_W-1:0]  div_max;

   assign mode_chg = (mode != mode_q);
   assign is_pass  = (mode_q == MODE_PASS);

   // Divider is cleared on any restart, held at 0 in PASS, frozen in HOLD.
   assign div_clr = mode_chg || is_pass ||
                    ((state_q == ST_HOLD) && (trig || !oneshot));
   assign div_en  = (state_q == ST_RUN) && !is_pass;
   assign div_max = (mode_q == MODE_BLINK) ? CNT_W'(BLINK_DIV - 1)
                                           : CNT_W'(STEP_DIV - 1);

   led_tick_gen #(.CNT_W(CNT_W)) u_tick (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (div_clr),
      .en      (div_en),
      .div_max (div_max),
      .tick    (tick)
   );

   always_comb begin
      seq_last = 1'b0;
      case (mode_q)
         MODE_SWEEP: seq_last = (step_q == SWEEP_LAST);
         MODE_BLINK: seq_last = (step_q == BLINK_LAST);
         MODE_COUNT: seq_last = (step_q == COUNT_LAST);
         default:    seq_last = 1'b0;
      endcase
   end

   // Next state: a mode change outranks everything, including a tick.
   always_comb begin
      mode_d  = mode_q;
      state_d = state_q;
      step_d  = step_q;
      done_d  = 1'b0;
      if (mode_chg) begin
         mode_d  = mode_e'(mode);
         state_d = ST_RUN;
         step_d  = '0;
      end else if (is_pass) begin
         state_d = ST_RUN;
         step_d  = '0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (tick) begin
                  if (seq_last) begin
                     step_d = '0;
                     if (oneshot) begin
                        state_d = ST_HOLD;
                        done_d  = 1'b1;
                     end
                  end else begin
                     step_d = step_q + 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               // Dropping oneshot while held resumes free-running.
               if (trig || !oneshot) begin
                  state_d = ST_RUN;
                  step_d  = '0;
               end
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   // Pattern decode from the current step; registered into led_q.
   always_comb begin
      led_d = '0;
      if (state_q == ST_RUN) begin
         case (mode_q)
            MODE_PASS:  led_d = pass_in;
            MODE_SWEEP: begin
               if (int'(step_q) < N_LED) begin
                  led_d = ONE << step_q;
               end else if (int'(step_q) < 2*N_LED - 1) begin
                  led_d = ONE << (2*N_LED - 2 - int'(step_q));
               end
            end
            MODE_BLINK: led_d = step_q[0] ? '0 : '1;
            MODE_COUNT: led_d = step_q[N_LED-1:0];
            default:    led_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q  <= MODE_PASS;
         state_q <= ST_RUN;
         step_q  <= '0;
         led_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         mode_q  <= mode_d;
         state_q <= state_d;
         step_q  <= step_d;
         led_q   <= led_d;
         done_q  <= done_d;
      end
   end

`ifdef LED_SEQ_PWM_EN
   logic [3:0] pwm_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt_q <= '0;
      end else begin
         pwm_cnt_q <= pwm_cnt_q + 4'd1;
      end
   end

   assign led = led_q & {N_LED{pwm_cnt_q < duty}};
`else
   assign led = led_q;
`endif

   assign busy = (state_q == ST_RUN) && !is_pass;
   assign done = done_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// ----------------------------------------------------------------------------
// tb_led_pattern_seq
//   Scoreboard bench: each scenario pushes the expected {done,busy,led} for
//   every upcoming cycle, then pops one entry per falling edge and compares.
//   Sim params: N_LED=4, STEP_DIV=4, BLINK_DIV=6, BLINK_CNT=2.
// ----------------------------------------------------------------------------
module tb_led_pattern_seq;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic [1:0] mode    = 2'b01;
   logic       oneshot = 1'b0;
   logic       trig    = 1'b0;
   logic [3:0] pass_in = 4'b0000;
   logic [3:0] led;
   logic       busy, done;
`ifdef LED_SEQ_PWM_EN
   logic [3:0] duty    = 4'd15;
`endif

   int         checks   = 0;
   int         failures = 0;
   logic [5:0] sb[$];
   logic [5:0] e;

   always #5 clk = ~clk;

   led_pattern_seq #(
      .N_LED(4), .STEP_DIV(4), .BLINK_DIV(6), .BLINK_CNT(2), .CNT_W(27)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .mode    (mode),
      .oneshot (oneshot),
      .trig    (trig),
      .pass_in (pass_in),
`ifdef LED_SEQ_PWM_EN
      .duty    (duty),
`endif
      .led     (led),
      .busy    (busy),
      .done    (done)
   );

   task automatic push(input logic d, input logic b, input logic [3:0] l, input int n);
      for (int i = 0; i < n; i++) sb.push_back({d, b, l});
   endtask

   task automatic test_reset();
      repeat (3) begin
         @(negedge clk);
         checks++;
         if ({done, busy, led} !== 6'b00_0000) begin
            failures++;
            $display("FAIL reset: got=%b exp=%b", {done, busy, led}, 6'b00_0000);
         end
      end
      rst_n = 1'b1;
   endtask

   task automatic test_sweep();
      logic [3:0] pat [8];
      pat = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000};
      push(1'b0, 1'b1, 4'b0000, 1);           // mode-change cycle still shows pass_in
      for (int i = 0; i < 8; i++) push(1'b0, 1'b1, pat[i], 4);
      push(1'b0, 1'b1, 4'b0001, 4);           // repeats
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if ({done, busy, led} !== e) begin
            failures++;
            $display("FAIL sweep: got=%b exp=%b", {done, busy, led}, e);
         end
      end
   endtask

   task automatic test_blink_oneshot();
      mode = 2'b10; oneshot = 1'b1;
      @(negedge clk);                         // mode-change cycle, old pattern
      push(1'b0, 1'b1, 4'b1111, 6);
      push(1'b0, 1'b1, 4'b0000, 6);
      push(1'b0, 1'b1, 4'b1111, 6);
      push(1'b0, 1'b1, 4'b0000, 5);
      push(1'b1, 1'b0, 4'b0000, 1);
      push(1'b0, 1'b0, 4'b0000, 8);
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if ({done, busy, led} !== e) begin
            failures++;
            $display("FAIL blink_oneshot: got=%b exp=%b", {done, busy, led}, e);
         end
      end
   endtask

   task automatic test_trig();
      int n;
      trig = 1'b1;
      push(1'b0, 1'b1, 4'b0000, 1);
      push(1'b0, 1'b1, 4'b1111, 6);
      push(1'b0, 1'b1, 4'b0000, 6);
      push(1'b0, 1'b1, 4'b1111, 6);
      push(1'b0, 1'b1, 4'b0000, 5);
      push(1'b1, 1'b0, 4'b0000, 1);
      push(1'b0, 1'b0, 4'b0000, 4);
      n = sb.size();
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if ({done, busy, led} !== e) begin
            failures++;
            $display("FAIL trig: got=%b exp=%b", {done, busy, led}, e);
         end
         trig = (i == 9);                     // second pulse lands mid-run: ignored
      end
   endtask

   task automatic test_count();
      mode = 2'b11; oneshot = 1'b0;
      push(1'b0, 1'b1, 4'b0000, 1);
      for (int v = 0; v < 16; v++) push(1'b0, 1'b1, 4'(v), 4);
      push(1'b0, 1'b1, 4'b0000, 4);
      for (int v = 1; v < 6; v++) push(1'b0, 1'b1, 4'(v), 4);
      push(1'b0, 1'b1, 4'b0110, 2);
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if ({done, busy, led} !== e) begin
            failures++;
            $display("FAIL count: got=%b exp=%b", {done, busy, led}, e);
         end
      end
   endtask

   task automatic test_reset_mid();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({done, busy, led} !== 6'b00_0000) begin
         failures++;
         $display("FAIL reset_mid_async: got=%b exp=%b", {done, busy, led}, 6'b00_0000);
      end
      @(negedge clk);
      checks++;
      if ({done, busy, led} !== 6'b00_0000) begin
         failures++;
         $display("FAIL reset_mid_held: got=%b exp=%b", {done, busy, led}, 6'b00_0000);
      end
      rst_n = 1'b1;
      push(1'b0, 1'b1, 4'b0000, 5);
      push(1'b0, 1'b1, 4'b0001, 4);
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if ({done, busy, led} !== e) begin
            failures++;
            $display("FAIL reset_mid_restart: got=%b exp=%b", {done, busy, led}, e);
         end
      end
   endtask

   task automatic test_pass();
      mode = 2'b01;
      @(negedge clk);
      push(1'b0, 1'b1, 4'b0001, 4);
      push(1'b0, 1'b1, 4'b0010, 2);
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if ({done, busy, led} !== e) begin
            failures++;
            $display("FAIL pass_pre: got=%b exp=%b", {done, busy, led}, e);
         end
      end
      mode = 2'b00; pass_in = 4'b1010;
      push(1'b0, 1'b0, 4'b0010, 1);
      push(1'b0, 1'b0, 4'b1010, 5);
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if ({done, busy, led} !== e) begin
            failures++;
            $display("FAIL pass_enter: got=%b exp=%b", {done, busy, led}, e);
         end
      end
      pass_in = 4'b0101;
      push(1'b0, 1'b0, 4'b0101, 2);
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if ({done, busy, led} !== e) begin
            failures++;
            $display("FAIL pass_follow: got=%b exp=%b", {done, busy, led}, e);
         end
      end
      mode = 2'b01;
      push(1'b0, 1'b1, 4'b0101, 1);
      push(1'b0, 1'b1, 4'b0001, 4);
      push(1'b0, 1'b1, 4'b0010, 1);
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if ({done, busy, led} !== e) begin
            failures++;
            $display("FAIL pass_exit: got=%b exp=%b", {done, busy, led}, e);
         end
      end
   endtask

   task automatic test_oneshot_resume();
      oneshot = 1'b1;                         // same mode: no restart, finishes this pass
      push(1'b0, 1'b1, 4'b0010, 3);
      push(1'b0, 1'b1, 4'b0100, 4);
      push(1'b0, 1'b1, 4'b1000, 4);
      push(1'b0, 1'b1, 4'b0100, 4);
      push(1'b0, 1'b1, 4'b0010, 4);
      push(1'b0, 1'b1, 4'b0001, 4);
      push(1'b0, 1'b1, 4'b0000, 3);
      push(1'b1, 1'b0, 4'b0000, 1);
      push(1'b0, 1'b0, 4'b0000, 3);
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if ({done, busy, led} !== e) begin
            failures++;
            $display("FAIL sweep_oneshot: got=%b exp=%b", {done, busy, led}, e);
         end
      end
      oneshot = 1'b0;
      push(1'b0, 1'b1, 4'b0000, 1);
      push(1'b0, 1'b1, 4'b0001, 4);
      push(1'b0, 1'b1, 4'b0010, 1);
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if ({done, busy, led} !== e) begin
            failures++;
            $display("FAIL oneshot_resume: got=%b exp=%b", {done, busy, led}, e);
         end
      end
   endtask

`ifdef LED_SEQ_PWM_EN
   task automatic test_pwm();
      int lit;
      mode = 2'b00; pass_in = 4'b1111; duty = 4'd4;
      repeat (3) @(negedge clk);
      lit = 0;
      repeat (16) begin
         @(negedge clk);
         if (led == 4'b1111) lit++;
      end
      checks++;
      if (lit !== 4) begin
         failures++;
         $display("FAIL pwm_duty4: got=%0d exp=%0d", lit, 4);
      end
      duty = 4'd0;
      @(negedge clk);
      lit = 0;
      repeat (16) begin
         @(negedge clk);
         if (led != 4'b0000) lit++;
      end
      checks++;
      if (lit !== 0) begin
         failures++;
         $display("FAIL pwm_duty0: got=%0d exp=%0d", lit, 0);
      end
   endtask
`endif

   initial begin
`ifdef LED_SEQ_PWM_EN
      test_pwm();
`else
      test_reset();
      test_sweep();
      test_blink_oneshot();
      test_trig();
      test_count();
      test_reset_mid();
      test_pass();
      test_oneshot_resume();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
